alu_muldiv_seq: RTL and testbench

//  Next-generation execute-stage ALU for the MIPS datapath. Single-cycle logic/arith/shift ops; iterative

---
 rtl/alu_pkg.sv | 27 ++
 rtl/muldiv_iter.sv | 82 ++++++++
 rtl/alu_muldiv_seq.sv | 120 ++++++++++++
 tb/tb_alu_muldiv_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the execute-stage ALU and its iterative mul/div engine.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package alu_pkg;

    // ALUCtrl opcodes; 14 and 15 are unassigned and produce a zero result.
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SGT  = 4'd5;
    localparam logic [3:0] ALU_NOT  = 4'd6;
    localparam logic [3:0] ALU_MULT = 4'd7;
    localparam logic [3:0] ALU_DIV  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_MFHI = 4'd12;
    localparam logic [3:0] ALU_MFLO = 4'd13;

    // Top-level FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (radix-2 shift-add) / restoring divider, one bit per cycle.
// Latency: go edge loads operands, DATA_WIDTH step cycles follow; fin flags the final step.
// Backpressure: none; go is honoured only by the owner when the engine is idle.
// Ports: clk, rst (async high), go/is_div (start + mode), a/b (operands),
//        busy (iterating), fin (final step this cycle), hi_o/lo_o (result of the current step).
module muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  is_div,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  fin,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic                  mode_div;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] acc;     // partial product high half / partial remainder
    logic [DATA_WIDTH-1:0] q;       // multiplier bits / dividend-quotient bits
    logic [DATA_WIDTH-1:0] opb;     // multiplicand / divisor

    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   shifted;
    logic                  ge;
    logic [DATA_WIDTH-1:0] sub_w;
    logic [DATA_WIDTH-1:0] nxt_acc;
    logic [DATA_WIDTH-1:0] nxt_q;

    assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, opb} : '0);
    assign shifted = {acc, q[DATA_WIDTH-1]};
    assign ge      = shifted >= {1'b0, opb};
    // When the trial subtraction succeeds the difference is below the divisor,
    // so a W-bit subtract is exact.
    assign sub_w   = shifted[DATA_WIDTH-1:0] - opb;

    always_comb begin
        nxt_acc = mul_sum[DATA_WIDTH:1];
        nxt_q   = {mul_sum[0], q[DATA_WIDTH-1:1]};
        if (mode_div) begin
            nxt_acc = ge ? sub_w : shifted[DATA_WIDTH-1:0];
            nxt_q   = {q[DATA_WIDTH-2:0], ge};
        end
    end

    assign fin  = busy && (cnt == LAST);
    assign hi_o = nxt_acc;
    assign lo_o = nxt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            mode_div <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            opb      <= '0;
        end else if (go) begin
            busy     <= 1'b1;
            mode_div <= is_div;
            cnt      <= '0;
            acc      <= '0;
            q        <= a;
            opb      <= b;
        end else if (busy) begin
            acc <= nxt_acc;
            q   <= nxt_q;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MULT/DIV into HI/LO.
// Latency: 1 cycle for single-cycle ops and DIV-by-zero; DATA_WIDTH+1 for MULT/DIV.
// Backpressure: busy=1 while MULT/DIV iterate; start during busy is dropped, not queued.
// Ports: clk, rst (async high), start/ALUCtrl/Shamt/A/B (issue), ALU_result/Zero/done (result),
//        busy, div_by_zero (sticky until next accept), hi/lo (architectural registers).
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 4,
    parameter int SHAMT_WIDTH   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CONTROL_WIDTH-1:0] ALUCtrl,
    input  logic [SHAMT_WIDTH-1:0]   Shamt,
    input  logic [DATA_WIDTH-1:0]    A,
    input  logic [DATA_WIDTH-1:0]    B,
    output logic [DATA_WIDTH-1:0]    ALU_result,
    output logic                     Zero,
    output logic                     busy,
    output logic                     done,
    output logic                     div_by_zero,
    output logic [DATA_WIDTH-1:0]    hi,
    output logic [DATA_WIDTH-1:0]    lo
);

    logic [1:0]            state;
    logic                  accept;
    logic                  is_mul;
    logic                  is_div;
    logic                  b_zero;
    logic                  go;
    logic                  eng_busy;
    logic                  eng_fin;
    logic [DATA_WIDTH-1:0] eng_hi;
    logic [DATA_WIDTH-1:0] eng_lo;
    logic [31:0]           sh_amt;
    logic [DATA_WIDTH-1:0] single_res;

    assign busy   = (state != ST_IDLE);
    assign accept = start && !busy;
    assign is_mul = (ALUCtrl == ALU_MULT);
    assign is_div = (ALUCtrl == ALU_DIV);
    assign b_zero = (B == '0);
    // Divide-by-zero resolves in one cycle, so the engine never starts for it.
    assign go     = accept && (is_mul || (is_div && !b_zero));
    assign sh_amt = 32'(Shamt) % 32'(DATA_WIDTH);
    assign Zero   = (ALU_result == '0);

    muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .is_div (is_div),
        .a      (A),
        .b      (B),
        .busy   (eng_busy),
        .fin    (eng_fin),
        .hi_o   (eng_hi),
        .lo_o   (eng_lo)
    );

    always_comb begin
        single_res = '0;
        case (ALUCtrl)
            ALU_AND:  single_res = A & B;
            ALU_OR:   single_res = A | B;
            ALU_ADD:  single_res = A + B;
            ALU_SUB:  single_res = A - B;
            ALU_SLT:  single_res = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
            ALU_SGT:  single_res = {{(DATA_WIDTH-1){1'b0}}, (A > B)};
            ALU_NOT:  single_res = ~A;
            ALU_SLL:  single_res = A << sh_amt;
            ALU_SRL:  single_res = A >> sh_amt;
            ALU_SRA:  single_res = $signed(A) >>> sh_amt;
            ALU_MFHI: single_res = hi;
            ALU_MFLO: single_res = lo;
            default:  single_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ALU_result  <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_by_zero <= 1'b0;
                if (is_mul) begin
                    state <= ST_MUL;
                end else if (is_div && !b_zero) begin
                    state <= ST_DIV;
                end else if (is_div) begin
                    hi          <= A;
                    lo          <= '1;
                    ALU_result  <= '1;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end else begin
                    ALU_result <= single_res;
                    done       <= 1'b1;
                end
            end else if (busy && eng_busy && eng_fin) begin
                hi         <= eng_hi;
                lo         <= eng_lo;
                ALU_result <= eng_lo;
                done       <= 1'b1;
                state      <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed corner cases plus random ops vs. an arithmetic model.
// Latency: expected done cycle is recorded per issued op and checked by the monitor.
// Backpressure: the driver waits for busy=0 before issuing; deliberate ignored starts are also driven.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ALUCtrl = 4'd0;
    logic [4:0]  Shamt = 5'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] ALU_result;
    logic        Zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    alu_muldiv_seq #(.DATA_WIDTH(32), .CONTROL_WIDTH(4), .SHAMT_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALUCtrl     (ALUCtrl),
        .Shamt       (Shamt),
        .A           (A),
        .B           (B),
        .ALU_result  (ALU_result),
        .Zero        (Zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=done required=no_done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", ALU_result, e.res);
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("zero", {31'd0, Zero}, {31'd0, (e.res == 32'd0)});
                chk("latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge. Waits for busy=0, drives the op for one cycle and records the expectation.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        int   guard = 0;
        exp_t e;
        logic [63:0] p;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            chk("issue_wait_busy", {31'd0, busy}, 32'd0);
        end
        e.dbz = 1'b0;
        e.due = cyc + 1;
        e.res = 32'd0;
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = a + b;
            4'd3:  e.res = a - b;
            4'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
            4'd5:  e.res = (a > b) ? 32'd1 : 32'd0;
            4'd6:  e.res = ~a;
            4'd7: begin
                p = {32'd0, a} * {32'd0, b};
                mhi = p[63:32];
                mlo = p[31:0];
                e.res = mlo;
                e.due = cyc + 33;
            end
            4'd8: begin
                if (b == 32'd0) begin
                    mhi = a;
                    mlo = 32'hFFFFFFFF;
                    e.dbz = 1'b1;
                end else begin
                    mlo = a / b;
                    mhi = a % b;
                    e.due = cyc + 33;
                end
                e.res = mlo;
            end
            4'd9:  e.res = a << sh;
            4'd10: e.res = a >> sh;
            4'd11: e.res = $signed(a) >>> sh;
            4'd12: e.res = mhi;
            4'd13: e.res = mlo;
            default: e.res = 32'd0;
        endcase
        e.hi = mhi;
        e.lo = mlo;
        sb.push_back(e);
        ALUCtrl = op;
        A = a;
        B = b;
        Shamt = sh;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_result", ALU_result, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_flags", {28'd0, busy, done, div_by_zero, Zero}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        // Wrap-around add, busy must stay low.
        issue(4'd2, 32'hFFFFFFFF, 32'd1, 5'd0);
        chk("add_busy", {31'd0, busy}, 32'd0);

        // Full-width multiply, a start during busy is dropped, MFHI in the done cycle.
        issue(4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        repeat (3) @(negedge clk);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        ALUCtrl = 4'd2;
        A = 32'd1;
        B = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(4'd12, 32'd0, 32'd0, 5'd0);
        issue(4'd13, 32'd0, 32'd0, 5'd0);

        // Division, divide-by-zero, sticky flag clears on the next op.
        issue(4'd8, 32'd100, 32'd7, 5'd0);
        issue(4'd8, 32'd5, 32'd0, 5'd0);
        issue(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
        issue(4'd7, 32'd3, 32'd5, 5'd0);
        issue(4'd2, 32'd10, 32'd20, 5'd0);

        // Reset in the middle of a division aborts without a done pulse.
        issue(4'd8, 32'd1000, 32'd7, 5'd0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        sb.delete();
        mhi = 32'd0;
        mlo = 32'd0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(4'd8, 32'd9, 32'd3, 5'd0);

        // Shifts and unassigned opcode.
        issue(4'd11, 32'h80000000, 32'd0, 5'd4);
        issue(4'd10, 32'h80000000, 32'd0, 5'd4);
        issue(4'd9, 32'h80000001, 32'd0, 5'd31);
        issue(4'd15, 32'h12345678, 32'h9ABCDEF0, 5'd0);
        issue(4'd4, 32'd1, 32'hFFFFFFFF, 5'd0);
        issue(4'd5, 32'hFFFFFFFF, 32'd1, 5'd0);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] rb;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)      rb = 32'd0;
            else if ($urandom_range(0, 1) == 0) rb = 32'($urandom_range(1, 50));
            else                                rb = $urandom;
            issue(op, $urandom, rb, 5'($urandom_range(0, 31)));
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
